spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
Parametrised next-generation SPI master driving up to slaves_g one-hot active-low slave selects on a shared spi_clk/mosi/miso bus. Adds per-transaction CPOL/CPHA, run-time clock divider, and multi-word bursts fed from an upstream FIFO. Sits between the host-side FIFO/register block and the spi_slave instances.

Parameters:
data_width_g, 8, bits per SPI word
slaves_g, 4, number of slave-select lines (>=1)
addr_width_g, 2, width of spi_slave_addr (>= ceil(log2(slaves_g)))
div_width_g, 8, width of clk_div
burst_width_g, 8, width of burst_len

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start  in  1  begin transaction; sampled only in IDLE
spi_slave_addr  in  addr_width_g  target slave index
cpol  in  1  clock polarity, latched at start
cpha  in  1  clock phase, latched at start
clk_div  in  div_width_g  half-period minus one, in clk cycles; latched at start
burst_len  in  burst_width_g  words in burst; latched at start
fifo_req_data  out  1  one-cycle read request to upstream FIFO
fifo_din  in  data_width_g  word from FIFO
fifo_din_valid  in  1  fifo_din valid, any cycle after request
fifo_empty  in  1  FIFO has no data
busy  out  1  high from accepted start until return to IDLE
dout  out  data_width_g  received word
dout_valid  out  1  one-cycle pulse per received word
done  out  1  one-cycle pulse at normal burst completion
err  out  1  one-cycle pulse on rejected start or underrun abort
spi_clk  out  1  SPI clock
spi_mosi  out  1  SPI data out
spi_miso  in  1  SPI data in
spi_ss  out  slaves_g  active-low selects, at most one low

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; spi_ss all ones; spi_clk=0; latched cpol=0; spi_mosi=0; busy, fifo_req_data, dout_valid, done, err = 0; dout=0. Reset mid-transfer aborts immediately, no done/err.
- Half period H = clk_div+1 clk cycles; clk_div=0 gives spi_clk=clk/2. Divider counter restarts at every state entry.
- States: IDLE, REQ, WAIT, SETUP, XFER, NEXT, HOLD.
- IDLE: spi_clk=latched cpol. start=1 with burst_len=0 or spi_slave_addr>=slaves_g -> err pulse next cycle, stay IDLE. start=1 with fifo_empty=1 -> err pulse, stay IDLE. Else latch config, busy=1, -> REQ.
- REQ: fifo_req_data=1 for exactly one cycle -> WAIT.
- WAIT: on fifo_din_valid load shift register; first word -> SETUP (spi_ss[addr]=0 same cycle); later words -> XFER directly (ss stays low).
- SETUP: hold ss low, spi_clk idle, for H cycles; cpha=0 puts MSB on mosi on ss fall.
- XFER: 2*data_width_g edges, each H cycles apart. cpha=0: sample miso on leading edge, shift mosi on trailing edge. cpha=1: shift on leading, sample on trailing. MSB first.
- After final edge: dout updated and dout_valid pulses one cycle later; remaining word counter decremented -> NEXT.
- NEXT: count=0 -> HOLD. count>0 and fifo_empty=0 -> REQ (spi_clk held idle, ss low, gap = H + FIFO latency). count>0 and fifo_empty=1 -> underrun: err pulse, -> HOLD.
- HOLD: ss stays low H cycles, then all ss high, further H cycles high, then done pulse (normal end only), busy=0, -> IDLE. Minimum ss-high between transactions = H.
- start while busy ignored. fifo_din_valid outside WAIT ignored. Inputs other than spi_miso, fifo_* not re-sampled during transaction.

Optional Feature:
SPI_LSB_FIRST_EN: when defined, adds input lsb_first (1 bit), latched at start; lsb_first=1 shifts mosi and assembles dout LSB first. When undefined, port absent and order is always MSB first.

Test Plan:
- Mode 0, clk_div=1, addr=2, burst_len=1, FIFO word 0xA5, slave miso 0x3C -> spi_ss=4'b1011, mosi 1,0,1,0,0,1,0,1, 8 spi_clk pulses of 4 clk period, dout=0x3C with one dout_valid, done pulse, busy low.
- Modes 1/2/3 each with 0x81 loopback (miso tied to mosi via slave) -> dout=0x81; spi_clk idles at cpol before and after, edges per cpha.
- burst_len=3, words 0x11,0x22,0x33 -> three fifo_req_data pulses, ss low continuously, three dout_valid, one done.
- burst_len=3, fifo_empty=1 after second word -> two dout_valid, err pulse, ss released, no done.
- start with addr=4 (slaves_g=4) or burst_len=0 -> err pulse, spi_ss stays 4'b1111, busy stays 0.
- rst=0 mid-word at bit 4 -> next edge spi_ss=4'b1111, spi_clk=0, busy=0; subsequent 0x5A transfer completes correctly.

Source files
------------

// File: rtl/spi_master_multi.sv
// -----------------------------------------------------------------------------
// spi_master_multi
//
// SPI master for a shared spi_clk/mosi/miso bus with up to slaves_g one-hot,
// active-low slave selects. Each transaction latches its own CPOL/CPHA, clock
// divider, target slave and burst length at start, then streams burst_len
// words pulled one at a time from an upstream FIFO. Every word is exchanged
// full duplex and the received word is presented on dout.
//
// Optional build macro:
//   SPI_LSB_FIRST_EN - adds input lsb_first, latched at start. When it is 1,
//                      mosi is shifted and dout assembled LSB first. Without
//                      the macro the port is absent and order is MSB first.
//
// Ports:
//   clk             system clock
//   rst             synchronous, active-low reset
//   start           begin a transaction (sampled only while idle)
//   spi_slave_addr  index of the slave to select
//   cpol, cpha      SPI mode for this transaction
//   clk_div         spi_clk half period minus one, in clk cycles
//   burst_len       number of words in the burst (0 is rejected)
//   fifo_req_data   one-cycle read request to the upstream FIFO
//   fifo_din        word returned by the FIFO
//   fifo_din_valid  fifo_din valid (any latency after the request)
//   fifo_empty      FIFO has no data
//   busy            high from accepted start until back in idle
//   dout            last received word
//   dout_valid      one-cycle pulse per received word
//   done            one-cycle pulse at normal burst completion
//   err             one-cycle pulse on rejected start or FIFO underrun
//   spi_clk         SPI clock
//   spi_mosi        SPI data out
//   spi_miso        SPI data in
//   spi_ss          active-low slave selects, at most one low
// -----------------------------------------------------------------------------
module spi_master_multi #(
   parameter int data_width_g  = 8,
   parameter int slaves_g      = 4,
   parameter int addr_width_g  = 2,
   parameter int div_width_g   = 8,
   parameter int burst_width_g = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [addr_width_g-1:0]  spi_slave_addr,
   input  logic                     cpol,
   input  logic                     cpha,
   input  logic [div_width_g-1:0]   clk_div,
   input  logic [burst_width_g-1:0] burst_len,
`ifdef SPI_LSB_FIRST_EN
   input  logic                     lsb_first,
`endif
   output logic                     fifo_req_data,
   input  logic [data_width_g-1:0]  fifo_din,
   input  logic                     fifo_din_valid,
   input  logic                     fifo_empty,
   output logic                     busy,
   output logic [data_width_g-1:0]  dout,
   output logic                     dout_valid,
   output logic                     done,
   output logic                     err,
   output logic                     spi_clk,
   output logic                     spi_mosi,
   input  logic                     spi_miso,
   output logic [slaves_g-1:0]      spi_ss
);

   localparam int edge_w_c = $clog2(2 * data_width_g);
   localparam logic [edge_w_c-1:0]     last_edge_c = edge_w_c'(2 * data_width_g - 1);
   localparam logic [addr_width_g:0]   slaves_c    = (addr_width_g + 1)'(slaves_g);

   typedef enum logic [2:0] {
      ST_IDLE, ST_REQ, ST_WAIT, ST_SETUP, ST_XFER, ST_NEXT, ST_HOLD
   } state_t;

   state_t                   state_reg, state_next;
   logic [div_width_g-1:0]   div_reg, div_next;
   logic [div_width_g-1:0]   clk_div_reg, clk_div_next;
   logic [edge_w_c-1:0]      edge_reg, edge_next;
   logic [burst_width_g-1:0] count_reg, count_next;
   logic [data_width_g-1:0]  tx_reg, tx_next;
   logic [data_width_g-1:0]  rx_reg, rx_next;
   logic [data_width_g-1:0]  dout_reg, dout_next;
   logic [addr_width_g-1:0]  addr_reg, addr_next;
   logic                     cpol_reg, cpol_next;
   logic                     cpha_reg, cpha_next;
   logic                     first_reg, first_next;
   logic                     ss_active_reg, ss_active_next;
   logic                     hold_phase_reg, hold_phase_next;
   logic                     underrun_reg, underrun_next;
   logic                     spi_clk_reg, spi_clk_next;
   logic                     mosi_reg, mosi_next;
   logic                     busy_reg, busy_next;
   logic                     req_reg, req_next;
   logic                     dout_valid_reg, dout_valid_next;
   logic                     done_reg, done_next;
   logic                     err_reg, err_next;
   logic                     div_restart;

`ifdef SPI_LSB_FIRST_EN
   logic                     lsb_reg, lsb_next;
`else
   logic                     lsb_reg;
   assign lsb_reg = 1'b0;
`endif

   // Datapath helpers, all derived from registered state.
   logic                    tick;
   logic                    sample_edge;
   logic                    last_edge;
   logic                    addr_bad;
   logic                    tx_bit;
   logic                    din_bit;
   logic [data_width_g-1:0] tx_shift;
   logic [data_width_g-1:0] din_shift;
   logic [data_width_g-1:0] rx_shift;

   assign tick        = (div_reg == clk_div_reg);
   // Even edge counts are leading edges; cpha=0 samples on leading,
   // cpha=1 samples on trailing, the other edge of each pair shifts mosi.
   assign sample_edge = (~edge_reg[0]) ^ cpha_reg;
   assign last_edge   = (edge_reg == last_edge_c);
   assign addr_bad    = ({1'b0, spi_slave_addr} >= slaves_c);
   assign tx_bit      = lsb_reg ? tx_reg[0] : tx_reg[data_width_g-1];
   assign tx_shift    = lsb_reg ? (tx_reg >> 1) : (tx_reg << 1);
   assign din_bit     = lsb_reg ? fifo_din[0] : fifo_din[data_width_g-1];
   assign din_shift   = lsb_reg ? (fifo_din >> 1) : (fifo_din << 1);
   assign rx_shift    = lsb_reg ? {spi_miso, rx_reg[data_width_g-1:1]}
                                : {rx_reg[data_width_g-2:0], spi_miso};

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      clk_div_next    = clk_div_reg;
      edge_next       = edge_reg;
      count_next      = count_reg;
      tx_next         = tx_reg;
      rx_next         = rx_reg;
      dout_next       = dout_reg;
      addr_next       = addr_reg;
      cpol_next       = cpol_reg;
      cpha_next       = cpha_reg;
      first_next      = first_reg;
      ss_active_next  = ss_active_reg;
      hold_phase_next = hold_phase_reg;
      underrun_next   = underrun_reg;
      spi_clk_next    = spi_clk_reg;
      mosi_next       = mosi_reg;
      busy_next       = busy_reg;
      req_next        = 1'b0;
      dout_valid_next = 1'b0;
      done_next       = 1'b0;
      err_next        = 1'b0;
      div_restart     = 1'b0;
`ifdef SPI_LSB_FIRST_EN
      lsb_next        = lsb_reg;
`endif

      case (state_reg)
         ST_IDLE: begin
            spi_clk_next = cpol_reg;
            if (start) begin
               if ((burst_len == '0) || addr_bad || fifo_empty) begin
                  err_next = 1'b1;
               end else begin
                  cpol_next       = cpol;
                  cpha_next       = cpha;
                  spi_clk_next    = cpol;
                  clk_div_next    = clk_div;
                  count_next      = burst_len;
                  addr_next       = spi_slave_addr;
`ifdef SPI_LSB_FIRST_EN
                  lsb_next        = lsb_first;
`endif
                  first_next      = 1'b1;
                  underrun_next   = 1'b0;
                  hold_phase_next = 1'b0;
                  busy_next       = 1'b1;
                  req_next        = 1'b1;
                  state_next      = ST_REQ;
               end
            end
         end

         // fifo_req_data is registered, so it is high for exactly this cycle.
         ST_REQ: state_next = ST_WAIT;

         ST_WAIT: begin
            if (fifo_din_valid) begin
               edge_next = '0;
               if (!cpha_reg) begin
                  // cpha=0: first bit must be on mosi before the first edge.
                  mosi_next = din_bit;
                  tx_next   = din_shift;
               end else begin
                  tx_next   = fifo_din;
               end
               if (first_reg) begin
                  first_next     = 1'b0;
                  ss_active_next = 1'b1;
                  state_next     = ST_SETUP;
               end else begin
                  state_next     = ST_XFER;
               end
            end
         end

         ST_SETUP: begin
            if (tick) state_next = ST_XFER;
         end

         ST_XFER: begin
            if (tick) begin
               spi_clk_next = ~spi_clk_reg;
               edge_next    = edge_reg + 1'b1;
               if (sample_edge) begin
                  rx_next = rx_shift;
               end else if (!last_edge) begin
                  // The final cpha=0 trailing edge has nothing left to send,
                  // so mosi keeps the last bit instead of shifting in filler.
                  mosi_next = tx_bit;
                  tx_next   = tx_shift;
               end
               if (last_edge) begin
                  dout_next       = rx_next;
                  dout_valid_next = 1'b1;
                  count_next      = count_reg - 1'b1;
                  state_next      = ST_NEXT;
               end
            end
         end

         ST_NEXT: begin
            if (count_reg == '0) begin
               state_next = ST_HOLD;
            end else if (fifo_empty) begin
               err_next      = 1'b1;
               underrun_next = 1'b1;
               state_next    = ST_HOLD;
            end else begin
               req_next   = 1'b1;
               state_next = ST_REQ;
            end
         end

         ST_HOLD: begin
            // Phase 0: select still low for H cycles.
            // Phase 1: select released, kept high H cycles before idle so
            // back-to-back transactions always see a deselect gap.
            if (tick) begin
               if (!hold_phase_reg) begin
                  ss_active_next  = 1'b0;
                  hold_phase_next = 1'b1;
                  div_restart     = 1'b1;
               end else begin
                  hold_phase_next = 1'b0;
                  done_next       = ~underrun_reg;
                  busy_next       = 1'b0;
                  state_next      = ST_IDLE;
               end
            end
         end

         default: state_next = ST_IDLE;
      endcase

      // Divider restarts on every state entry and after every tick.
      if ((state_next != state_reg) || div_restart || tick) begin
         div_next = '0;
      end else begin
         div_next = div_reg + 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         div_reg        <= '0;
         clk_div_reg    <= '0;
         edge_reg       <= '0;
         count_reg      <= '0;
         tx_reg         <= '0;
         rx_reg         <= '0;
         dout_reg       <= '0;
         addr_reg       <= '0;
         cpol_reg       <= 1'b0;
         cpha_reg       <= 1'b0;
         first_reg      <= 1'b0;
         ss_active_reg  <= 1'b0;
         hold_phase_reg <= 1'b0;
         underrun_reg   <= 1'b0;
         spi_clk_reg    <= 1'b0;
         mosi_reg       <= 1'b0;
         busy_reg       <= 1'b0;
         req_reg        <= 1'b0;
         dout_valid_reg <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
         lsb_reg        <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         div_reg        <= div_next;
         clk_div_reg    <= clk_div_next;
         edge_reg       <= edge_next;
         count_reg      <= count_next;
         tx_reg         <= tx_next;
         rx_reg         <= rx_next;
         dout_reg       <= dout_next;
         addr_reg       <= addr_next;
         cpol_reg       <= cpol_next;
         cpha_reg       <= cpha_next;
         first_reg      <= first_next;
         ss_active_reg  <= ss_active_next;
         hold_phase_reg <= hold_phase_next;
         underrun_reg   <= underrun_next;
         spi_clk_reg    <= spi_clk_next;
         mosi_reg       <= mosi_next;
         busy_reg       <= busy_next;
         req_reg        <= req_next;
         dout_valid_reg <= dout_valid_next;
         done_reg       <= done_next;
         err_reg        <= err_next;
`ifdef SPI_LSB_FIRST_EN
         lsb_reg        <= lsb_next;
`endif
      end
   end

   // One-hot active-low select decode from the latched address.
   generate
      for (genvar gi = 0; gi < slaves_g; gi++) begin : g_ss
         assign spi_ss[gi] = ~(ss_active_reg && (addr_reg == addr_width_g'(gi)));
      end
   endgenerate

   assign fifo_req_data = req_reg;
   assign busy          = busy_reg;
   assign dout          = dout_reg;
   assign dout_valid    = dout_valid_reg;
   assign done          = done_reg;
   assign err           = err_reg;
   assign spi_clk       = spi_clk_reg;
   assign spi_mosi      = mosi_reg;

endmodule

// File: tb/tb_spi_master_multi.sv
// -----------------------------------------------------------------------------
// tb_spi_master_multi
//
// Directed bench for spi_master_multi: a FIFO responder, a behavioural SPI
// slave (shift register or mosi loopback) and a cycle monitor feed a single
// checking task. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_spi_master_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] spi_slave_addr;
   logic       cpol;
   logic       cpha;
   logic [7:0] clk_div;
   logic [7:0] burst_len;
   logic       fifo_req_data;
   logic [7:0] fifo_din = 8'h00;
   logic       fifo_din_valid = 1'b0;
   logic       fifo_empty;
   logic       busy;
   logic [7:0] dout;
   logic       dout_valid;
   logic       done;
   logic       err;
   logic       spi_clk;
   logic       spi_mosi;
   logic       spi_miso;
   logic [3:0] spi_ss;

   always #5 clk = ~clk;

   spi_master_multi #(
      .data_width_g  (8),
      .slaves_g      (4),
      .addr_width_g  (3),
      .div_width_g   (8),
      .burst_width_g (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .spi_slave_addr (spi_slave_addr),
      .cpol           (cpol),
      .cpha           (cpha),
      .clk_div        (clk_div),
      .burst_len      (burst_len),
      .fifo_req_data  (fifo_req_data),
      .fifo_din       (fifo_din),
      .fifo_din_valid (fifo_din_valid),
      .fifo_empty     (fifo_empty),
      .busy           (busy),
      .dout           (dout),
      .dout_valid     (dout_valid),
      .done           (done),
      .err            (err),
      .spi_clk        (spi_clk),
      .spi_mosi       (spi_mosi),
      .spi_miso       (spi_miso),
      .spi_ss         (spi_ss)
   );

   // ---------------- FIFO responder: data two cycles after request ----------
   logic [7:0] fifo_words [0:7];
   int         fifo_n = 0;
   int         rd_idx = 0;
   logic       fifo_rewind = 1'b0;
   logic       pend = 1'b0;
   logic [7:0] pend_data = 8'h00;

   assign fifo_empty = (rd_idx >= fifo_n);

   always @(posedge clk) begin
      fifo_din_valid <= 1'b0;
      if (fifo_rewind) begin
         rd_idx <= 0;
         pend   <= 1'b0;
      end else begin
         if (fifo_req_data && rd_idx < 8) begin
            pend_data <= fifo_words[rd_idx];
            rd_idx    <= rd_idx + 1;
            pend      <= 1'b1;
         end
         if (pend) begin
            fifo_din       <= pend_data;
            fifo_din_valid <= 1'b1;
            pend           <= 1'b0;
         end
      end
   end

   // ---------------- SPI slave model ----------------------------------------
   logic [7:0] miso_words [0:7];
   logic [7:0] slv_got [0:7];
   logic       loopback = 1'b0;
   logic       m_cpol = 1'b0;
   logic       m_cpha = 1'b0;
   logic       slv_miso = 1'b0;
   logic [7:0] slv_tx = 8'h00;
   logic [7:0] slv_sr = 8'h00;
   int         slv_txb = 0;
   int         slv_nb = 0;
   int         slv_widx = 0;
   int         slv_words = 0;
   logic       prev_sclk_s = 1'b0;
   logic       prev_idle_s = 1'b1;
   logic       ss_idle;

   assign ss_idle  = &spi_ss;
   assign spi_miso = loopback ? spi_mosi : slv_miso;

   always @(spi_clk or ss_idle) begin : slave
      logic lead;
      if (prev_idle_s && !ss_idle) begin
         slv_nb    = 0;
         slv_words = 0;
         slv_txb   = 0;
         slv_widx  = 0;
         slv_tx    = miso_words[0];
         slv_miso  = slv_tx[7];
      end else if (!ss_idle && (spi_clk != prev_sclk_s)) begin
         lead = (spi_clk != m_cpol);
         if (lead ^ m_cpha) begin
            slv_sr = {slv_sr[6:0], spi_mosi};
            slv_nb++;
            if (slv_nb == 8) begin
               slv_got[slv_words % 8] = slv_sr;
               slv_words++;
               slv_nb = 0;
            end
         end else begin
            slv_txb++;
            if (slv_txb == 8) begin
               slv_txb  = 0;
               slv_widx++;
               slv_tx   = miso_words[slv_widx % 8];
            end else begin
               slv_tx = slv_tx << 1;
            end
            slv_miso = slv_tx[7];
         end
      end
      prev_sclk_s = spi_clk;
      prev_idle_s = ss_idle;
   end

   // ---------------- Cycle monitor ------------------------------------------
   int         cyc = 0;
   int         rise_cnt = 0;
   int         per_min = 1000;
   int         per_max = 0;
   int         last_rise = -1;
   int         dv_cnt = 0;
   int         done_cnt = 0;
   int         err_cnt = 0;
   int         req_cnt = 0;
   int         ss_rise_cnt = 0;
   int         ss_multi = 0;
   logic [7:0] dv_log [0:7];
   logic [3:0] ss_seen = 4'hF;
   logic       prev_sclk_m = 1'b0;
   logic       prev_idle_m = 1'b1;

   always @(negedge clk) begin
      cyc++;
      if (spi_clk === 1'b1 && prev_sclk_m === 1'b0) begin
         rise_cnt++;
         if (last_rise >= 0) begin
            if (cyc - last_rise < per_min) per_min = cyc - last_rise;
            if (cyc - last_rise > per_max) per_max = cyc - last_rise;
         end
         last_rise = cyc;
      end
      if (dout_valid === 1'b1) begin
         dv_log[dv_cnt % 8] = dout;
         dv_cnt++;
      end
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (fifo_req_data === 1'b1) req_cnt++;
      if (ss_idle === 1'b0) ss_seen = spi_ss;
      if (ss_idle === 1'b1 && prev_idle_m === 1'b0) ss_rise_cnt++;
      if ($countones(~spi_ss) > 1) ss_multi++;
      prev_sclk_m = spi_clk;
      prev_idle_m = ss_idle;
   end

   // ---------------- Checking ------------------------------------------------
   int n_checks = 0;
   int n_fail = 0;
   int s_dv, s_done, s_err, s_req, s_rise, s_ssr;
   logic sclk_at_start;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      s_dv   = dv_cnt;
      s_done = done_cnt;
      s_err  = err_cnt;
      s_req  = req_cnt;
      s_rise = rise_cnt;
      s_ssr  = ss_rise_cnt;
   endtask

   task automatic load(input int n, input logic [7:0] w0, w1, w2,
                       input logic [7:0] m0, m1, m2);
      fifo_words[0] = w0; fifo_words[1] = w1; fifo_words[2] = w2;
      miso_words[0] = m0; miso_words[1] = m1; miso_words[2] = m2;
      fifo_n = n;
      @(negedge clk);
      fifo_rewind = 1'b1;
      @(negedge clk);
      fifo_rewind = 1'b0;
   endtask

   task automatic kick(input logic [2:0] a, input logic pl, input logic ph,
                       input logic [7:0] dv, input logic [7:0] bl);
      @(negedge clk);
      spi_slave_addr = a;
      cpol           = pl;
      cpha           = ph;
      clk_div        = dv;
      burst_len      = bl;
      start          = 1'b1;
      @(negedge clk);
      start          = 1'b0;
      sclk_at_start  = spi_clk;
   endtask

   task automatic run_txn(input logic [2:0] a, input logic pl, input logic ph,
                          input logic [7:0] dv, input logic [7:0] bl);
      kick(a, pl, ph, dv, bl);
      for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
      check_val("busy_end", busy, 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; spi_slave_addr = 3'd0; cpol = 1'b0; cpha = 1'b0;
      clk_div = 8'd0; burst_len = 8'd0;
      for (int i = 0; i < 8; i++) begin
         fifo_words[i] = 8'h00; miso_words[i] = 8'h00; slv_got[i] = 8'h00; dv_log[i] = 8'h00;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_ss", spi_ss, 4'hF);
      check_val("rst_sclk", spi_clk, 0);
      check_val("rst_mosi", spi_mosi, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_dout", dout, 0);
      check_val("rst_pulses", {fifo_req_data, dout_valid, done, err}, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Mode 0, clk_div=1, slave 2, 0xA5 out / 0x3C in
      m_cpol = 0; m_cpha = 0; loopback = 0;
      load(1, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
      snap();
      run_txn(3'd2, 1'b0, 1'b0, 8'd1, 8'd1);
      check_val("m0_ss", ss_seen, 4'b1011);
      check_val("m0_mosi_word", slv_got[0], 8'hA5);
      check_val("m0_slv_words", slv_words, 1);
      check_val("m0_sclk_pulses", rise_cnt - s_rise, 8);
      check_val("m0_per_min", per_min, 4);
      check_val("m0_per_max", per_max, 4);
      check_val("m0_dv_cnt", dv_cnt - s_dv, 1);
      check_val("m0_dout", dv_log[(dv_cnt - 1) % 8], 8'h3C);
      check_val("m0_done", done_cnt - s_done, 1);
      check_val("m0_err", err_cnt - s_err, 0);
      check_val("m0_sclk_idle", spi_clk, 0);

      // Modes 1..3 with mosi looped back to miso
      for (int m = 1; m < 4; m++) begin
         m_cpol = m[1]; m_cpha = m[0]; loopback = 1;
         load(1, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
         snap();
         run_txn(3'd1, m[1], m[0], 8'd2, 8'd1);
         check_val($sformatf("mode%0d_sclk_before", m), sclk_at_start, m[1]);
         check_val($sformatf("mode%0d_sclk_after", m), spi_clk, m[1]);
         check_val($sformatf("mode%0d_dout", m), dv_log[(dv_cnt - 1) % 8], 8'h81);
         check_val($sformatf("mode%0d_slave_rx", m), slv_got[0], 8'h81);
         check_val($sformatf("mode%0d_done", m), done_cnt - s_done, 1);
      end
      loopback = 0; m_cpol = 0; m_cpha = 0;

      // Burst of three words at clk_div=0
      load(3, 8'h11, 8'h22, 8'h33, 8'hC1, 8'hC2, 8'hC3);
      snap();
      run_txn(3'd1, 1'b0, 1'b0, 8'd0, 8'd3);
      check_val("burst_req", req_cnt - s_req, 3);
      check_val("burst_dv", dv_cnt - s_dv, 3);
      check_val("burst_dout0", dv_log[(dv_cnt - 3) % 8], 8'hC1);
      check_val("burst_dout1", dv_log[(dv_cnt - 2) % 8], 8'hC2);
      check_val("burst_dout2", dv_log[(dv_cnt - 1) % 8], 8'hC3);
      check_val("burst_done", done_cnt - s_done, 1);
      check_val("burst_ss_rise", ss_rise_cnt - s_ssr, 1);
      check_val("burst_slv_words", slv_words, 3);
      check_val("burst_slv_w2", slv_got[2], 8'h33);
      check_val("burst_ss", ss_seen, 4'b1101);

      // Underrun: burst of three, FIFO holds only two
      load(2, 8'h44, 8'h55, 8'h00, 8'hD1, 8'hD2, 8'h00);
      snap();
      run_txn(3'd3, 1'b0, 1'b0, 8'd1, 8'd3);
      check_val("under_dv", dv_cnt - s_dv, 2);
      check_val("under_dout", dv_log[(dv_cnt - 1) % 8], 8'hD2);
      check_val("under_err", err_cnt - s_err, 1);
      check_val("under_done", done_cnt - s_done, 0);
      check_val("under_req", req_cnt - s_req, 2);
      check_val("under_ss", spi_ss, 4'hF);

      // Rejected starts
      load(1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      snap();
      run_txn(3'd4, 1'b0, 1'b0, 8'd1, 8'd1);
      check_val("badaddr_err", err_cnt - s_err, 1);
      check_val("badaddr_req", req_cnt - s_req, 0);
      check_val("badaddr_ss", ss_rise_cnt - s_ssr, 0);
      snap();
      run_txn(3'd1, 1'b0, 1'b0, 8'd1, 8'd0);
      check_val("zerolen_err", err_cnt - s_err, 1);
      check_val("zerolen_req", req_cnt - s_req, 0);
      load(0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      snap();
      run_txn(3'd1, 1'b0, 1'b0, 8'd1, 8'd1);
      check_val("empty_err", err_cnt - s_err, 1);
      check_val("empty_done", done_cnt - s_done, 0);
      check_val("ss_onehot", ss_multi, 0);

      // Reset in the middle of a word
      load(1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      kick(3'd2, 1'b0, 1'b0, 8'd1, 8'd1);
      for (int i = 0; i < 1000 && !(slv_nb == 4 && !ss_idle); i++) @(negedge clk);
      check_val("mid_bit4", slv_nb, 4);
      snap();
      rst = 1'b0;
      @(negedge clk);
      check_val("mid_rst_ss", spi_ss, 4'hF);
      check_val("mid_rst_sclk", spi_clk, 0);
      check_val("mid_rst_busy", busy, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("mid_rst_nodone", done_cnt - s_done, 0);
      check_val("mid_rst_noerr", err_cnt - s_err, 0);

      load(1, 8'h5A, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00);
      snap();
      run_txn(3'd2, 1'b0, 1'b0, 8'd1, 8'd1);
      check_val("post_rst_dout", dv_log[(dv_cnt - 1) % 8], 8'hA5);
      check_val("post_rst_slave", slv_got[0], 8'h5A);
      check_val("post_rst_done", done_cnt - s_done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
